// File: rtl/csm_pkg.sv
// ============================================================================
// Module      : csm_pkg
// Description : Shared types and helpers for the carry-save multiplier
//               merge stage (FSM state enum, width helper, default sizing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csm_pkg;

  // Merge-stage control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } csm_state_e;

  // Counter width that never collapses to zero bits (a single chunk still
  // needs a 1-bit index register).
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 32'd1) ? 32'd1 : 32'($clog2(value));
  endfunction

  // Default sizing of the stage.
  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_CHUNK = 4;
  localparam int unsigned NCHUNK    = DEF_N / DEF_CHUNK;
  localparam int unsigned IDX_W     = clog2_min1(NCHUNK);

endpackage

`default_nettype wire

// File: rtl/csm_chunk_adder.sv
// ============================================================================
// Module      : csm_chunk_adder
// Description : Combinational CHUNK-bit ripple-carry adder built from the
//               csm_fa cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csm_chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      csm_fa u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (c[i]),
        .s    (s[i]),
        .cout (c[i+1])
      );
    end
  endgenerate

  assign cout = c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/csm_fa.sv
// ============================================================================
// Module      : csm_fa
// Description : Single-bit full adder cell (a + b + cin -> s, cout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csm_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/csm_merge_stage.sv
// ============================================================================
// Module      : csm_merge_stage
// Description : Final carry-save multiplier stage. Resolves the redundant
//               upper sum/carry vectors with a chunked ripple merge, one
//               CHUNK-bit slice per clock, and emits the 2N-bit product over
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csm_merge_stage
  import csm_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   sum_vec_i,
  input  logic [N-1:0]   carry_vec_i,
  input  logic [N-1:0]   lsb_prod_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] product_o,
  output logic           err_o
);

  localparam int unsigned     CHUNKS   = N / CHUNK;
  localparam int unsigned     CNT_W    = clog2_min1(CHUNKS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

  generate
    if ((N % CHUNK) != 0) begin : g_chunk_check
      $error("csm_merge_stage: N must be a multiple of CHUNK");
    end
  endgenerate

  csm_state_e       state;
  csm_state_e       state_next;
  logic [CNT_W-1:0] idx;
  logic             carry;
  logic [N-1:0]     sum_reg;
  logic [N-1:0]     carry_reg;
  logic [N-1:0]     lsb_reg;
  logic [N-1:0]     result_reg;
  logic [N-1:0]     result_next;
  logic [2*N-1:0]   product_reg;
  logic             err_reg;
  logic             accept;
  logic             is_last;
  logic [CHUNK-1:0] add_a;
  logic [CHUNK-1:0] add_b;
  logic [CHUNK-1:0] add_s;
  logic             add_cout;

  assign in_ready_o  = (state == IDLE) | ((state == DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign is_last     = (idx == LAST_IDX);
  assign out_valid_o = (state == DONE);
  assign product_o   = product_reg;
  assign err_o       = err_reg;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (idx == CNT_W'(k)) begin
        add_a = sum_reg[k*CHUNK +: CHUNK];
        add_b = carry_reg[k*CHUNK +: CHUNK];
      end
    end
  end

  csm_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  // Merge the freshly added slice into the partial result.
  always_comb begin
    result_next = result_reg;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (idx == CNT_W'(k)) begin
        result_next[k*CHUNK +: CHUNK] = add_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = MERGE;
      MERGE:   if (is_last) state_next = DONE;
      DONE:    if (out_ready_i) state_next = in_valid_i ? MERGE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, chunk walk and result publication.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx         <= '0;
      carry       <= 1'b0;
      sum_reg     <= '0;
      carry_reg   <= '0;
      lsb_reg     <= '0;
      result_reg  <= '0;
      product_reg <= '0;
      err_reg     <= 1'b0;
    end else if (accept) begin
      sum_reg   <= sum_vec_i;
      carry_reg <= carry_vec_i;
      lsb_reg   <= lsb_prod_i;
      idx       <= '0;
      carry     <= 1'b0;
    end else if (state == MERGE) begin
      result_reg <= result_next;
      carry      <= add_cout;
      if (is_last) begin
        // Index returns to zero so a single-chunk build keeps idx at 0.
        idx         <= '0;
        err_reg     <= add_cout;
        product_reg <= {result_next, lsb_reg};
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csm_merge_stage.sv
// ============================================================================
// Module      : tb_csm_merge_stage
// Description : Directed bench for csm_merge_stage with CHUNK = 4 as the main
//               instance plus CHUNK = 1, 2, 8 instances for a random sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csm_merge_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  sum_vec;
  logic [7:0]  carry_vec;
  logic [7:0]  lsb_prod;
  logic        in_ready  [4];
  logic        out_valid [4];
  logic [15:0] product   [4];
  logic        err       [4];

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] sv;
  logic [7:0] cv;
  logic [7:0] lv;
  logic [3:0] got;

  always #5 clk = ~clk;

  // Index 0: CHUNK=4, 1: CHUNK=1, 2: CHUNK=2, 3: CHUNK=8
  csm_merge_stage #(.N(8), .CHUNK(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .sum_vec_i(sum_vec), .carry_vec_i(carry_vec), .lsb_prod_i(lsb_prod),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .product_o(product[0]), .err_o(err[0]));

  csm_merge_stage #(.N(8), .CHUNK(1)) u_dut_c1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .sum_vec_i(sum_vec), .carry_vec_i(carry_vec), .lsb_prod_i(lsb_prod),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .product_o(product[1]), .err_o(err[1]));

  csm_merge_stage #(.N(8), .CHUNK(2)) u_dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .sum_vec_i(sum_vec), .carry_vec_i(carry_vec), .lsb_prod_i(lsb_prod),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready), .product_o(product[2]), .err_o(err[2]));

  csm_merge_stage #(.N(8), .CHUNK(8)) u_dut_c8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[3]),
    .sum_vec_i(sum_vec), .carry_vec_i(carry_vec), .lsb_prod_i(lsb_prod),
    .out_valid_o(out_valid[3]), .out_ready_i(out_ready), .product_o(product[3]), .err_o(err[3]));

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s, input logic [7:0] c, input logic [7:0] l);
    sum_vec   = s;
    carry_vec = c;
    lsb_prod  = l;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(8'h00, 8'h00, 8'h00);
    tick();
    tick();

    // Reset state
    check_value("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_value("rst_product",   32'(product[0]),   32'h0);
    check_value("rst_err",       32'(err[0]),       32'd0);
    check_value("rst_in_ready",  32'(in_ready[0]),  32'd1);
    rst_n = 1'b1;
    tick();

    // 1: carry crosses the chunk boundary, two-edge latency
    drive(8'h0F, 8'h01, 8'h55);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_value("t1_busy_e0", 32'(out_valid[0]), 32'd0);
    tick();
    check_value("t1_busy_e1", 32'(out_valid[0]), 32'd0);
    tick();
    check_value("t1_valid",   32'(out_valid[0]), 32'd1);
    check_value("t1_product", 32'(product[0]),   32'h1055);
    check_value("t1_err",     32'(err[0]),       32'd0);
    tick();
    check_value("t1_idle_valid", 32'(out_valid[0]), 32'd0);
    check_value("t1_idle_hold",  32'(product[0]),   32'h1055);

    // 2: overflow out of the MSB chunk
    drive(8'hFF, 8'h01, 8'h00);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_value("t2_valid",   32'(out_valid[0]), 32'd1);
    check_value("t2_product", 32'(product[0]),   32'h0000);
    check_value("t2_err",     32'(err[0]),       32'd1);
    tick();

    // 3: backpressure holds the result and blocks new input
    drive(8'h12, 8'h34, 8'hAB);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    drive(8'hFF, 8'hFF, 8'hFF);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_value("t3_valid",    32'(out_valid[0]), 32'd1);
      check_value("t3_in_ready", 32'(in_ready[0]),  32'd0);
      check_value("t3_product",  32'(product[0]),   32'h46AB);
      check_value("t3_err",      32'(err[0]),       32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_value("t3_release_valid", 32'(out_valid[0]), 32'd0);
    tick();
    tick();
    tick();
    check_value("t3_no_accept", 32'(out_valid[0]), 32'd0);
    check_value("t3_hold",      32'(product[0]),   32'h46AB);

    // 4: back-to-back, second operand set taken in the DONE cycle
    drive(8'h21, 8'h10, 8'h01);
    in_valid = 1'b1;
    tick();
    drive(8'h80, 8'h7F, 8'h02);
    check_value("t4_merge_not_ready", 32'(in_ready[0]), 32'd0);
    tick();
    tick();
    check_value("t4_a_valid",    32'(out_valid[0]), 32'd1);
    check_value("t4_a_product",  32'(product[0]),   32'h3101);
    check_value("t4_done_ready", 32'(in_ready[0]),  32'd1);
    tick();
    in_valid = 1'b0;
    check_value("t4_b_busy", 32'(out_valid[0]), 32'd0);
    tick();
    tick();
    check_value("t4_b_valid",   32'(out_valid[0]), 32'd1);
    check_value("t4_b_product", 32'(product[0]),   32'hFF02);
    check_value("t4_b_err",     32'(err[0]),       32'd0);
    tick();

    // 5: reset while the second chunk is being merged
    drive(8'h0F, 8'h01, 8'h77);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_value("t5_valid",    32'(out_valid[0]), 32'd0);
    check_value("t5_product",  32'(product[0]),   32'h0);
    check_value("t5_in_ready", 32'(in_ready[0]),  32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_value("t5_no_output", 32'(out_valid[0]), 32'd0);
      check_value("t5_ready",     32'(in_ready[0]),  32'd1);
    end

    // 6: random sweep across CHUNK = 4, 1, 2, 8
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int t = 0; t < 1000; t++) begin
      sv = 8'($urandom_range(0, 255));
      cv = 8'($urandom_range(0, 32'd255 - 32'(sv)));
      lv = 8'($urandom_range(0, 255));
      drive(sv, cv, lv);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      got = 4'h0;
      for (int w = 0; w < 12 && got != 4'hF; w++) begin
        tick();
        for (int i = 0; i < 4; i++) begin
          if (!got[i] && out_valid[i]) begin
            check_value("sweep_upper", 32'(product[i][15:8]), 32'(sv) + 32'(cv));
            check_value("sweep_lower", 32'(product[i][7:0]),  32'(lv));
            check_value("sweep_err",   32'(err[i]),           32'd0);
            got[i] = 1'b1;
          end
        end
      end
      check_value("sweep_all_done", 32'(got), 32'hF);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
